// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl - parses 4-byte UART command frames and drives two DDS channel configs
// Frame is HEADER, CMD, FREQ, CHK; a valid frame updates one channel and pulses its flag.
module dds_cfg_ctrl #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          UART_BPS      = 9600,
  parameter int          TIMEOUT_BYTES = 4,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ch0_sel,
  output logic [6:0] ch0_freq,
  output logic       ch0_flag,
  output logic       ch1_sel,
  output logic [6:0] ch1_freq,
  output logic       ch1_flag,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  localparam int TO_CYC = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FREQ  = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;

  logic [2:0]      state;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      cmd_q;
  logic [7:0]      freq_q;
  logic            in_frame;
  logic            expire;
  logic            frame_ok;

  assign in_frame = (state == S_CMD) || (state == S_FREQ) || (state == S_CHK);
  assign busy     = in_frame;
  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire   = in_frame && !rx_valid && (to_cnt == TO_LAST);
  // Reserved-bit and FREQ[7] checks are deferred to CHK so every frame is 4 bytes long.
  assign frame_ok = (cmd_q[6:1] == 6'd0) && !freq_q[7] && (rx_data == (cmd_q ^ freq_q));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      cmd_q     <= 8'd0;
      freq_q    <= 8'd0;
      ch0_sel   <= 1'b0;
      ch0_freq  <= 7'd0;
      ch0_flag  <= 1'b0;
      ch1_sel   <= 1'b0;
      ch1_freq  <= 7'd0;
      ch1_flag  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      ch0_flag  <= 1'b0;
      ch1_flag  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid || expire)
        to_cnt <= '0;
      else if (in_frame)
        to_cnt <= to_cnt + 1'b1;

      case (state)
        S_IDLE, S_APPLY: begin
          state <= (rx_valid && rx_data == HEADER) ? S_CMD : S_IDLE;
        end
        S_CMD, S_FREQ: begin
          if (rx_valid) begin
            if (state == S_CMD) begin
              cmd_q <= rx_data;
              state <= S_FREQ;
            end else begin
              freq_q <= rx_data;
              state  <= S_CHK;
            end
          end else if (expire) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            if (frame_ok) begin
              state     <= S_APPLY;
              frame_cnt <= frame_cnt + 8'd1;
              if (cmd_q[0]) begin
                ch1_sel  <= cmd_q[7];
                ch1_freq <= freq_q[6:0];
                ch1_flag <= 1'b1;
              end else begin
                ch0_sel  <= cmd_q[7];
                ch0_freq <= freq_q[6:0];
                ch0_flag <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end else if (expire) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// tb_dds_cfg_ctrl - randomized frame stimulus checked against a frame-level reference model
module tb_dds_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       ch0_sel, ch0_flag, ch1_sel, ch1_flag, busy, frame_err;
  logic [6:0] ch0_freq, ch1_freq;
  logic [7:0] frame_cnt;

  dds_cfg_ctrl #(
    .CLK_FREQ(1000), .UART_BPS(100), .TIMEOUT_BYTES(4), .HEADER(8'hA5)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .ch0_sel(ch0_sel), .ch0_freq(ch0_freq), .ch0_flag(ch0_flag),
    .ch1_sel(ch1_sel), .ch1_freq(ch1_freq), .ch1_flag(ch1_flag),
    .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: channel configuration and accepted-frame count
  logic       m_sel [2];
  logic [6:0] m_freq [2];
  logic [7:0] m_cnt;
  int exp_f0 = 0, exp_f1 = 0, exp_err = 0;
  int seen_f0 = 0, seen_f1 = 0, seen_err = 0, seen_clash = 0;

  always @(negedge clk) begin
    if (ch0_flag) seen_f0++;
    if (ch1_flag) seen_f1++;
    if (frame_err) seen_err++;
    if ((ch0_flag && ch1_flag) || (frame_err && (ch0_flag || ch1_flag))) seen_clash++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ch0_sel"}, 32'(ch0_sel), 32'(m_sel[0]));
    check({tag, ".ch0_freq"}, 32'(ch0_freq), 32'(m_freq[0]));
    check({tag, ".ch1_sel"}, 32'(ch1_sel), 32'(m_sel[1]));
    check({tag, ".ch1_freq"}, 32'(ch1_freq), 32'(m_freq[1]));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic check_pulses(input string tag);
    check({tag, ".f0_cycles"}, 32'(seen_f0), 32'(exp_f0));
    check({tag, ".f1_cycles"}, 32'(seen_f1), 32'(exp_f1));
    check({tag, ".err_cycles"}, 32'(seen_err), 32'(exp_err));
  endtask

  task automatic model_reset();
    m_sel[0] = 1'b0; m_sel[1] = 1'b0;
    m_freq[0] = 7'd0; m_freq[1] = 7'd0;
    m_cnt = 8'd0;
  endtask

  // Sends a full frame; on return we sit in the cycle right after the CHK byte.
  task automatic send_frame(input string tag, input logic [7:0] cmd,
                            input logic [7:0] freq, input logic [7:0] chk);
    bit ok;
    int ch;
    ok = (cmd[6:1] == 6'd0) && (freq[7] == 1'b0) && (chk == (cmd ^ freq));
    ch = int'(cmd[0]);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(freq);
    send_byte(chk);
    if (ok) begin
      m_sel[ch]  = cmd[7];
      m_freq[ch] = freq[6:0];
      m_cnt      = m_cnt + 8'd1;
      if (ch == 1) exp_f1++; else exp_f0++;
    end else begin
      exp_err++;
    end
    check({tag, ".flag"}, 32'({ch1_flag, ch0_flag}), ok ? (ch == 1 ? 32'd2 : 32'd1) : 32'd0);
    check({tag, ".err"}, 32'(frame_err), 32'(!ok));
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] cmd, freq, chk, noise;
    int n;
    model_reset();
    idle(3);
    check_outputs("reset");
    check("reset.flags", 32'({ch1_flag, ch0_flag, frame_err, busy}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    send_frame("t1", 8'h81, 8'h25, 8'hA4);
    send_frame("t2", 8'h00, 8'h10, 8'h11);
    send_byte(8'h00);
    send_byte(8'h33);
    send_frame("t3", 8'h00, 8'h7F, 8'h7F);
    idle(1);
    send_frame("t3_freq7", 8'h00, 8'h80, 8'h80);
    idle(1);
    send_frame("t3_rsvd", 8'h02, 8'h10, 8'h12);
    idle(1);
    check_pulses("directed");

    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        noise = 8'($urandom);
        if (noise == 8'hA5) noise = 8'h5A;
        send_byte(noise);
      end
      cmd  = {1'($urandom), ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0, 1'($urandom)};
      freq = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {1'b0, 7'($urandom)};
      chk  = cmd ^ freq;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      send_frame("rand", cmd, freq, chk);
    end
    idle(1);
    check_pulses("random");

    // Timeout: stall after CMD and count cycles to frame_err
    send_byte(8'hA5);
    send_byte(8'h01);
    check("to.busy_high", 32'(busy), 32'd1);
    n = 0;
    while (!frame_err && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_err++;
    check("to.cycles", 32'(n), 32'd400);
    check("to.busy_low", 32'(busy), 32'd0);
    send_frame("to.after", 8'h01, 8'h05, 8'h04);

    // Byte arriving exactly at expiry must win
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(399);
    send_byte(8'h06);
    check("to.edge_no_err", 32'(frame_err), 32'd0);
    check("to.edge_busy", 32'(busy), 32'd1);
    send_byte(8'h07);
    m_sel[1] = 1'b0; m_freq[1] = 7'h06; m_cnt = m_cnt + 8'd1; exp_f1++;
    check("to.edge_flag", 32'(ch1_flag), 32'd1);
    check_outputs("to.edge");
    idle(1);
    check_pulses("timeout");

    // Asynchronous reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h81);
    send_byte(8'h25);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(1);
    send_byte(8'hA4);
    check("rst.a4_ignored", 32'({ch1_flag, ch0_flag, frame_err, busy}), 32'd0);
    check_outputs("rst.a4");
    send_frame("rst.after", 8'h80, 8'h33, 8'hB3);

    // 256 back-to-back frames, next header in the APPLY cycle
    idle(1);
    rst_n = 1'b0;
    #1;
    model_reset();
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 256; i++) begin
      cmd  = {1'($urandom), 6'd0, 1'($urandom)};
      freq = {1'b0, 7'($urandom)};
      send_frame("b2b", cmd, freq, cmd ^ freq);
    end
    check("b2b.wrap", 32'(frame_cnt), 32'd0);
    idle(2);
    check_pulses("final");
    check("clash", 32'(seen_clash), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
